// File: rtl/mau_pkg.sv
// mau_pkg: shared widths, load/store state encoding and reset defaults for
// the memory access unit (mem_access_unit and its fetch_unit).
package mau_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 20;

    // Default fetch start address; overridable per instance.
    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 10'd0;

    // Load/store sequencer states (2-bit encoding).
    typedef enum logic [1:0] {
        LS_IDLE  = 2'd0,
        LS_READ  = 2'd1,
        LS_WRITE = 2'd2,
        LS_DONE  = 2'd3
    } ls_state_e;

    // Sequential PC step; wraps naturally at the 10-bit boundary.
    function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
        return pc + 10'd1;
    endfunction

endpackage

// File: rtl/mem_access_unit_fetch.sv
// fetch_unit: owns the program counter, presents fetched instructions to the
// core, and handles stall (hold) and branch redirect (flush). The memory
// latches PC on the falling edge, so inst belongs to the current pc at the
// next rising edge.
module fetch_unit
    import mau_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              if_stall_i,
    input  logic [DATA_W-1:0] inst_i,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_inst_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] inst_q,    inst_d;
    logic [ADDR_W-1:0] if_pc_q,   if_pc_d;

    // Next-state: branch beats stall, stall holds a presented instruction.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        if_pc_d = if_pc_q;
        if (branch_taken_i) begin
            pc_d    = branch_target_i;
            valid_d = 1'b0;
        end else if (valid_q && if_stall_i) begin
            pc_d    = pc_q;
            valid_d = valid_q;
        end else begin
            inst_d  = inst_i;
            if_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_incr(pc_q);
        end
    end

    // Fetch state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= 20'd0;
            if_pc_q <= 10'd0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            if_pc_q <= if_pc_d;
        end
    end

    assign if_valid_o = valid_q;
    assign if_inst_o  = inst_q;
    assign if_pc_o    = if_pc_q;
    assign pc_o       = pc_q;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side requester for the instruction/data memory.
// Fetch (fetch_unit) and the load/store sequencer run concurrently.
// Optional build macro: MAU_BOUNDS_CHECK_EN -- when defined, accesses with
// ls_addr >= DMEM_DEPTH complete immediately with ls_err; otherwise ls_err
// is tied low and addresses wrap within 10 bits.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC     = RESET_PC_DEF,
    parameter int unsigned       READ_LATENCY = 1,
    parameter int unsigned       DMEM_DEPTH   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              if_stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write,
    output logic              wr_select,
    input  logic [DATA_W-1:0] read,
    input  logic [DATA_W-1:0] inst
);

    // Wait count loaded on load acceptance; reaches 0 on the capture cycle.
    localparam logic [2:0] READ_CNT_INIT = 3'(READ_LATENCY - 1);

    ls_state_e         state_q,  state_d;
    logic [2:0]        cnt_q,    cnt_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              wr_sel_q, wr_sel_d;
    logic              ack_q,    ack_d;
    logic              oob_s;

    fetch_unit #(
        .RESET_PC (RESET_PC)
    ) u_fetch (
        .clk_i           (clk),
        .reset_i         (reset),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .if_stall_i      (if_stall),
        .inst_i          (inst),
        .if_valid_o      (if_valid),
        .if_inst_o       (if_inst),
        .if_pc_o         (if_pc),
        .pc_o            (PC)
    );

`ifdef MAU_BOUNDS_CHECK_EN
    logic err_q, err_d;
    assign oob_s  = (32'(ls_addr) >= DMEM_DEPTH);
    assign ls_err = err_q;
`else
    assign oob_s  = 1'b0;
    assign ls_err = 1'b0;
`endif

    // Load/store next-state: wr_select and ls_ack are decoded one cycle ahead
    // so that the registered versions line up with LS_WRITE and LS_DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        wr_sel_d = 1'b0;
        ack_d    = 1'b0;
`ifdef MAU_BOUNDS_CHECK_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            LS_IDLE: begin
                if (ls_req) begin
                    addr_d  = ls_addr;
                    wdata_d = ls_wdata;
                    if (oob_s) begin
                        // Out-of-range: skip the memory cycle entirely.
                        state_d = LS_DONE;
                        ack_d   = 1'b1;
                        rdata_d = 20'd0;
`ifdef MAU_BOUNDS_CHECK_EN
                        err_d   = 1'b1;
`endif
                    end else if (ls_we) begin
                        state_d  = LS_WRITE;
                        wr_sel_d = 1'b1;
                    end else begin
                        state_d = LS_READ;
                        cnt_d   = READ_CNT_INIT;
                    end
                end else begin
                    state_d = LS_IDLE;
                end
            end
            LS_READ: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = read;
                    state_d = LS_DONE;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            LS_WRITE: begin
                // RAM commits on the edge closing this cycle.
                state_d = LS_DONE;
                ack_d   = 1'b1;
            end
            LS_DONE: begin
                state_d = LS_IDLE;
            end
            default: begin
                state_d = LS_IDLE;
            end
        endcase
    end

    // Load/store registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LS_IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= 10'd0;
            wdata_q  <= 20'd0;
            rdata_q  <= 20'd0;
            wr_sel_q <= 1'b0;
            ack_q    <= 1'b0;
`ifdef MAU_BOUNDS_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wr_sel_q <= wr_sel_d;
            ack_q    <= ack_d;
`ifdef MAU_BOUNDS_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign addr      = addr_q;
    assign write     = wdata_q;
    assign wr_select = wr_sel_q;
    assign ls_ack    = ack_q;
    assign ls_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expectations, two
// monitors pop and compare when the DUT presents a fetch or an ls_ack.
module tb_mem_access_unit;

    localparam logic [9:0] T_RESET_PC = 10'h010;
    localparam int unsigned T_RL      = 2;
    localparam int unsigned T_DEPTH   = 256;

    typedef struct {
        logic [19:0] rdata;
        logic        err;
        int          lat;
        int          wrs;
        int          acc;
    } ls_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        branch_taken = 1'b0;
    logic [9:0]  branch_target = 10'd0;
    logic        if_stall = 1'b0;
    logic        if_valid;
    logic [19:0] if_inst;
    logic [9:0]  if_pc;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [9:0]  ls_addr = 10'd0;
    logic [19:0] ls_wdata = 20'd0;
    logic        ls_ack;
    logic [19:0] ls_rdata;
    logic        ls_err;
    logic [9:0]  PC;
    logic [9:0]  addr;
    logic [19:0] write;
    logic        wr_select;
    logic [19:0] read;
    logic [19:0] inst = 20'd0;
    logic [19:0] dmem [0:1023];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_cnt = 0;
    logic [29:0] fq[$];
    ls_exp_t     lq[$];

    mem_access_unit #(
        .RESET_PC     (T_RESET_PC),
        .READ_LATENCY (T_RL),
        .DMEM_DEPTH   (T_DEPTH)
    ) dut (
        .clk (clk), .reset (reset),
        .branch_taken (branch_taken), .branch_target (branch_target),
        .if_stall (if_stall), .if_valid (if_valid), .if_inst (if_inst), .if_pc (if_pc),
        .ls_req (ls_req), .ls_we (ls_we), .ls_addr (ls_addr), .ls_wdata (ls_wdata),
        .ls_ack (ls_ack), .ls_rdata (ls_rdata), .ls_err (ls_err),
        .PC (PC), .addr (addr), .write (write), .wr_select (wr_select),
        .read (read), .inst (inst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory model: latches PC on the falling edge, inst = PC + 0x100.
    always @(negedge clk) inst <= {10'h000, PC} + 20'h00100;

    // Data memory model: write on rising edge, asynchronous read.
    always @(posedge clk) if (wr_select) dmem[addr] <= write;
    assign read = dmem[addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_fetch(input logic [9:0] pc);
        fq.push_back({pc, {10'h000, pc} + 20'h00100});
    endtask

    // Fetch monitor: compares each instruction the core actually takes.
    initial begin
        logic [29:0] fe;
        forever begin
            @(negedge clk);
            if (!reset && if_valid && !if_stall && !branch_taken && fq.size() > 0) begin
                fe = fq.pop_front();
                chk("fetch_pc",   {22'h0, if_pc},   {22'h0, fe[29:20]});
                chk("fetch_inst", {12'h0, if_inst}, {12'h0, fe[19:0]});
            end
        end
    end

    // Load/store monitor: counts write-enable cycles and checks each ack.
    initial begin
        ls_exp_t le;
        forever begin
            @(negedge clk);
            if (reset) begin
                wr_cnt = 0;
            end else begin
                if (wr_select) wr_cnt++;
                if (ls_ack) begin
                    if (lq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL ls_unexpected_ack: actual=1 required=0 at cycle %0d", cyc);
                    end else begin
                        le = lq.pop_front();
                        chk("ls_rdata",   {12'h0, ls_rdata}, {12'h0, le.rdata});
                        chk("ls_err",     {31'h0, ls_err},   {31'h0, le.err});
                        chk("ls_latency", 32'(cyc + 1 - le.acc), 32'(le.lat));
                        chk("ls_wr_cycles", 32'(wr_cnt), 32'(le.wrs));
                    end
                    wr_cnt = 0;
                end
            end
        end
    end

    // One load/store transaction; returns at the negedge where ls_ack is seen.
    task automatic ls_op(input logic we, input logic [9:0] a, input logic [19:0] wd,
                         input logic [19:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int exp_wr, input string nm);
        ls_exp_t e;
        bit got;
        @(posedge clk); #1;
        e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat; e.wrs = exp_wr; e.acc = cyc + 1;
        lq.push_back(e);
        ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ls_ack) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: actual=no ls_ack required=ls_ack within 20 cycles", nm);
            void'(lq.pop_back());
        end
        ls_req = 1'b0;
    endtask

    task automatic wait_pc(input logic [9:0] target, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (if_valid && if_pc == target) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: actual=not presented required=if_pc %h", nm, target);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc",        {22'h0, PC},       {22'h0, T_RESET_PC});
        chk("rst_if_valid",  {31'h0, if_valid}, 32'h0);
        chk("rst_if_inst",   {12'h0, if_inst},  32'h0);
        chk("rst_if_pc",     {22'h0, if_pc},    32'h0);
        chk("rst_ls_ack",    {31'h0, ls_ack},   32'h0);
        chk("rst_ls_rdata",  {12'h0, ls_rdata}, 32'h0);
        chk("rst_ls_err",    {31'h0, ls_err},   32'h0);
        chk("rst_addr",      {22'h0, addr},     32'h0);
        chk("rst_write",     {12'h0, write},    32'h0);
        chk("rst_wr_select", {31'h0, wr_select}, 32'h0);

        // Sequential fetch from RESET_PC, then a 3-cycle stall at 0x012.
        for (int p = 16; p <= 20; p++) push_fetch(10'(p));
        reset = 1'b0;
        wait_pc(10'h012, "stall_entry");
        if_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_if_pc",    {22'h0, if_pc},    32'h012);
            chk("stall_if_inst",  {12'h0, if_inst},  32'h00112);
            chk("stall_if_valid", {31'h0, if_valid}, 32'h1);
            chk("stall_PC",       {22'h0, PC},       32'h013);
        end
        if_stall = 1'b0;

        // Branch to 0x3FF while stalled: flush, then 0x3FF and wrap to 0x000.
        wait_pc(10'h015, "branch_entry");
        chk("fetch_queue_pre_branch", 32'(fq.size()), 32'd0);
        if_stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 10'h3FF;
        push_fetch(10'h3FF);
        push_fetch(10'h000);
        push_fetch(10'h001);
        @(posedge clk); #1;
        branch_taken = 1'b0;
        if_stall = 1'b0;
        chk("branch_flush_valid", {31'h0, if_valid}, 32'h0);
        chk("branch_PC",          {22'h0, PC},       32'h3FF);

        // Store then load (READ_LATENCY=2), plus a second address.
        ls_op(1'b1, 10'h005, 20'hABCDE, 20'h00000, 1'b0, 2, 1, "store5");
        ls_op(1'b0, 10'h005, 20'h00000, 20'hABCDE, 1'b0, 3, 0, "load5");
        ls_op(1'b1, 10'h3FF, 20'h12345, 20'hABCDE, 1'b0, 2, 1, "store3ff");
        chk("hold_addr",  {22'h0, addr},  32'h3FF);
        chk("hold_write", {12'h0, write}, 32'h12345);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold_addr",  {22'h0, addr},      32'h3FF);
        chk("idle_wr_select",  {31'h0, wr_select}, 32'h0);
        ls_op(1'b0, 10'h3FF, 20'h00000, 20'h12345, 1'b0, 3, 0, "load3ff");
        ls_op(1'b0, 10'h005, 20'h00000, 20'hABCDE, 1'b0, 3, 0, "reload5");

        // Reset while in LS_READ: dropped, no ack; fetch restarts.
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'h005;
        @(posedge clk); #1;
        reset = 1'b1;
        ls_req = 1'b0;
        for (int p = 16; p <= 18; p++) push_fetch(10'(p));
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_read_no_ack",   {31'h0, ls_ack},    32'h0);
            chk("rst_read_wr_sel",   {31'h0, wr_select}, 32'h0);
            chk("rst_read_rdata",    {12'h0, ls_rdata},  32'h0);
        end
        ls_op(1'b1, 10'h007, 20'h55555, 20'h00000, 1'b0, 2, 1, "store7_after_rst");
        ls_op(1'b0, 10'h007, 20'h00000, 20'h55555, 1'b0, 3, 0, "load7");

`ifdef MAU_BOUNDS_CHECK_EN
        ls_op(1'b1, 10'h100, 20'h77777, 20'h00000, 1'b1, 1, 0, "oob_store");
        ls_op(1'b0, 10'h2FF, 20'h00000, 20'h00000, 1'b1, 1, 0, "oob_load");
        ls_op(1'b0, 10'h007, 20'h00000, 20'h55555, 1'b0, 3, 0, "inrange_load");
`endif

        // Drain and confirm every expectation was consumed.
        for (int i = 0; i < 20 && (fq.size() > 0 || lq.size() > 0); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("fetch_queue_empty", 32'(fq.size()), 32'd0);
        chk("ls_queue_empty",    32'(lq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
